// File: rtl/sa_lockstep_feeder.sv
// Lockstep operand feeder for the systolic array input ports.
// Buffers nCh upstream streams in per-channel FIFOs and issues one beat to
// all array ports at once, only when every port is write-ready. A schedule
// token stream selects a data beat or a zero bubble per issue slot.
module sa_lockstep_feeder #(
  parameter int nCh        = 6,
  parameter int dWidth     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    n_beats,
  input  logic [nCh*dWidth-1:0]   src_data,
  input  logic [nCh-1:0]          src_valid,
  output logic [nCh-1:0]          src_ready,
  input  logic                    sched_en,
  input  logic                    sched_valid,
  output logic                    sched_ready,
  input  logic [nCh-1:0]          dst_wrdy,
  output logic [nCh*dWidth-1:0]   dst_data,
  output logic                    dst_en,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    beats_issued,
  output logic [CNT_WIDTH-1:0]    stall_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   n_beats_lat;
  logic [CNT_WIDTH-1:0]   beats_nxt;
  logic [nCh-1:0]         nonempty;
  logic [nCh*dWidth-1:0]  head_data;
  logic                   fire_p0;
  logic                   pop_p0;

  // Saturating increment so the stall counter pins at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ---- stage p0: FIFO heads and lockstep issue decision ----
  assign fire_p0     = (state == RUN) & (&dst_wrdy) & sched_valid &
                       (~sched_en | (&nonempty));
  assign pop_p0      = fire_p0 & sched_en;
  assign sched_ready = fire_p0;
  assign beats_nxt   = beats_issued + CNT_WIDTH'(1);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  for (genvar ch = 0; ch < nCh; ch++) begin : g_fifo
    logic [dWidth-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              full;
    logic              push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign nonempty[ch] = (wptr != rptr);
    // A full FIFO refuses the push even if it is popped in the same cycle.
    assign push  = src_valid[ch] & ~full;
    assign src_ready[ch] = ~full;
    assign head_data[ch*dWidth +: dWidth] = mem[rptr[AW-1:0]];

    // Pointer update; reset discards any queued words.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push)   wptr <= wptr + 1'b1;
        if (pop_p0) rptr <= rptr + 1'b1;
      end
    end

    // Storage write; contents are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= src_data[ch*dWidth +: dWidth];
    end
  end

  // ---- stage p1: registered array outputs, run control and counters ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n_beats_lat  <= '0;
      beats_issued <= '0;
      stall_cycles <= '0;
      dst_en       <= 1'b0;
      dst_data     <= '0;
    end else begin
      dst_en <= 1'b0;
      if (fire_p0) begin
        if (sched_en) begin
          dst_en   <= 1'b1;
          dst_data <= head_data;
        end else begin
          dst_data <= '0;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            beats_issued <= '0;
            stall_cycles <= '0;
            n_beats_lat  <= n_beats;
            state        <= (n_beats == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pop_p0) begin
            beats_issued <= beats_nxt;
            if (beats_nxt == n_beats_lat) state <= DONE;
          end
          if (!fire_p0) stall_cycles <= sat_inc(stall_cycles);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_lockstep_feeder.sv
// Self-checking bench for sa_lockstep_feeder: directed scenarios plus
// randomized runs, compared cycle by cycle against a queue-based model.
module tb_sa_lockstep_feeder;
  localparam int NCH   = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [CW-1:0]         n_beats;
  logic [NCH*DW-1:0]     src_data;
  logic [NCH-1:0]        src_valid;
  logic [NCH-1:0]        src_ready;
  logic                  sched_en;
  logic                  sched_valid;
  logic                  sched_ready;
  logic [NCH-1:0]        dst_wrdy;
  logic [NCH*DW-1:0]     dst_data;
  logic                  dst_en;
  logic                  busy;
  logic                  done;
  logic [CW-1:0]         beats_issued;
  logic [CW-1:0]         stall_cycles;

  always #5 clk = ~clk;

  sa_lockstep_feeder #(.nCh(NCH), .dWidth(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .n_beats(n_beats),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .sched_en(sched_en), .sched_valid(sched_valid), .sched_ready(sched_ready),
    .dst_wrdy(dst_wrdy), .dst_data(dst_data), .dst_en(dst_en),
    .busy(busy), .done(done), .beats_issued(beats_issued), .stall_cycles(stall_cycles)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: per-channel word queues, run phase, counters, outputs.
  logic [DW-1:0]     mq [NCH][$];
  bit                tq [$];
  int                nxt [NCH];
  int                m_st;     // 0 idle, 1 running, 2 done
  int                m_beats, m_stall, m_nl;
  logic              m_en;
  logic [NCH*DW-1:0] m_data;

  // Bench drive controls.
  logic [NCH-1:0] push_mask;
  logic [NCH-1:0] wr_drv;
  bit             tok_gate;
  bit             start_drv;
  int             nb_drv;
  bit             rand_mode;
  int             en_seen;

  function automatic logic [DW-1:0] word(input int ch, input int k);
    return DW'(16 * ch + k);
  endfunction

  // One clock: drive inputs, check combinational outputs, step model, check registers.
  task automatic cycle();
    bit             f, se, sv, allne;
    logic [NCH-1:0] acc, rdy;
    if (rand_mode) begin
      push_mask = NCH'($urandom);
      wr_drv    = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
      tok_gate  = ($urandom_range(0, 4) != 0);
    end
    for (int i = 0; i < NCH; i++) src_data[i*DW +: DW] = word(i, nxt[i]);
    src_valid = push_mask;
    dst_wrdy  = wr_drv;
    sv = tok_gate && (tq.size() > 0);
    se = (tq.size() > 0) ? tq[0] : 1'b0;
    sched_valid = sv;
    sched_en    = se;
    start       = start_drv;
    n_beats     = CW'(nb_drv);
    allne = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (mq[i].size() == 0) allne = 1'b0;
      rdy[i] = (mq[i].size() < DEPTH);
      acc[i] = push_mask[i] && rdy[i];
    end
    f = (m_st == 1) && (&wr_drv) && sv && (!se || allne);
    #1;
    check("src_ready", src_ready, rdy);
    check("sched_ready", sched_ready, f);
    @(posedge clk);
    #1;
    if (f) begin
      if (se) begin
        for (int i = 0; i < NCH; i++) m_data[i*DW +: DW] = mq[i].pop_front();
        m_en = 1'b1;
        m_beats++;
      end else begin
        m_en   = 1'b0;
        m_data = '0;
      end
      tq.delete(0);
    end else begin
      m_en = 1'b0;
    end
    for (int i = 0; i < NCH; i++)
      if (acc[i]) begin
        mq[i].push_back(word(i, nxt[i]));
        nxt[i]++;
      end
    if (m_st == 1 && !f && m_stall < (1 << CW) - 1) m_stall++;
    case (m_st)
      0: if (start_drv) begin
           m_beats = 0;
           m_stall = 0;
           m_nl    = nb_drv;
           m_st    = (nb_drv == 0) ? 2 : 1;
         end
      1: if (f && se && m_beats == m_nl) m_st = 2;
      default: m_st = 0;
    endcase
    check("dst_en", dst_en, m_en);
    check("dst_data", dst_data, m_data);
    check("busy", busy, m_st == 1);
    check("done", done, m_st == 2);
    check("beats_issued", beats_issued, m_beats);
    check("stall_cycles", stall_cycles, m_stall);
    if (dst_en) en_seen++;
    start_drv = 1'b0;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    cycle();
    while (m_st != 0 && n < bound) begin
      cycle();
      n++;
    end
    if (m_st != 0) check("run_timeout", 1, 0);
  endtask

  task automatic begin_run(input int nb);
    start_drv = 1'b1;
    nb_drv    = nb;
    en_seen   = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dst_en"}, dst_en, 0);
    check({tag, "_dst_data"}, dst_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_beats"}, beats_issued, 0);
    check({tag, "_stall"}, stall_cycles, 0);
    check({tag, "_src_ready"}, src_ready, {NCH{1'b1}});
    check({tag, "_sched_ready"}, sched_ready, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) mq[i].delete();
    tq.delete();
    m_st = 0; m_beats = 0; m_stall = 0; m_nl = 0;
    m_en = 1'b0; m_data = '0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) nxt[i] = 0;
    model_reset();
    push_mask = '0; wr_drv = '1; tok_gate = 1'b1; start_drv = 1'b0;
    nb_drv = 0; rand_mode = 1'b0; en_seen = 0;
    rst = 1'b0; start = 1'b0; n_beats = '0; src_data = '0; src_valid = '0;
    sched_en = 1'b0; sched_valid = 1'b0; dst_wrdy = '1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;

    // Streaming: prefill, then 8 back-to-back data beats while refilling.
    push_mask = '1;
    repeat (4) cycle();
    tq = '{1, 1, 1, 1, 1, 1, 1, 1};
    begin_run(8);
    run_until_idle(100);
    check("stream_beats", en_seen, 8);
    check("stream_stall", stall_cycles, 0);

    // Bubbles: schedule 1,0,0,1,1 with three data beats, no refill.
    push_mask = '0;
    tq = '{1, 0, 0, 1, 1};
    begin_run(3);
    run_until_idle(100);
    check("bubble_beats", en_seen, 3);

    // Backpressure: one port drops write-ready for five cycles mid-run.
    push_mask = '1;
    repeat (3) cycle();
    tq = '{1, 1, 1, 1, 1, 1, 1, 1};
    begin_run(8);
    repeat (3) cycle();
    wr_drv[4] = 1'b0;
    repeat (5) cycle();
    wr_drv = '1;
    run_until_idle(100);
    check("bp_stall", stall_cycles, 5);
    check("bp_beats", en_seen, 8);

    // Drain every FIFO, then fill all channels except channel 2.
    push_mask = '0;
    tq.delete();
    for (int i = 0; i < mq[0].size(); i++) tq.push_back(1'b1);
    begin_run(mq[0].size());
    run_until_idle(100);
    push_mask = 6'b111011;
    repeat (6) cycle();
    // Starvation: bubbles fire, the data token waits for channel 2.
    tq = '{0, 0, 1, 0};
    begin_run(1);
    repeat (6) cycle();
    check("starve_beats", beats_issued, 0);
    push_mask = '1;
    run_until_idle(100);
    check("starve_done_beats", en_seen, 1);

    // Zero-length run goes straight to done.
    tq = '{1};
    begin_run(0);
    cycle();
    cycle();
    check("zero_beats", en_seen, 0);

    // Start during a run is ignored.
    tq = '{1, 1, 1};
    begin_run(3);
    cycle();
    start_drv = 1'b1;
    nb_drv    = 7;
    run_until_idle(100);
    check("restart_ignored", beats_issued, 3);

    // Randomized runs.
    rand_mode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int nb, ones;
      nb = $urandom_range(1, 10);
      ones = 0;
      tq.delete();
      while (ones < nb) begin
        bit b;
        b = ($urandom_range(0, 3) != 0);
        tq.push_back(b);
        if (b) ones++;
      end
      begin_run(nb);
      run_until_idle(400);
    end
    rand_mode = 1'b0;
    wr_drv = '1; tok_gate = 1'b1;

    // Asynchronous reset mid-run.
    push_mask = '1;
    tq = '{1, 1, 1, 1, 1, 1, 1, 1};
    begin_run(8);
    repeat (4) cycle();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    push_mask = '0; src_valid = '0; sched_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // FIFOs must be empty: a data token cannot fire until words arrive.
    tq = '{1};
    begin_run(1);
    repeat (3) cycle();
    check("arst_empty_beats", beats_issued, 0);
    push_mask = '1;
    run_until_idle(100);
    check("arst_after_beats", en_seen, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
